// File: rtl/lc_stream_pkg.sv
// Shared constants, beat type and helpers for the lc_* stream blocks.
package lc_stream_pkg;

  localparam int LC_DATA_SIZE_DEFAULT  = 32;
  localparam int LC_FIFO_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic                            last;
    logic [LC_DATA_SIZE_DEFAULT-1:0] data;
  } lc_beat_t;

  // True when v is a power of two no smaller than two.
  function automatic logic is_pow2_min2(input int unsigned v);
    return (v >= 32'd2) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/lc_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module lc_fifo_mem
  import lc_stream_pkg::*;
#(
  parameter int WIDTH = LC_DATA_SIZE_DEFAULT + 1,
  parameter int DEPTH = LC_FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/lc_stream_fifo.sv
// Synchronous stream FIFO with tlast, occupancy count and completed-frame counter.
module lc_stream_fifo
  import lc_stream_pkg::*;
#(
  parameter int DATA_SIZE = LC_DATA_SIZE_DEFAULT,
  parameter int DEPTH     = LC_FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_SIZE-1:0]     s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic [DATA_SIZE-1:0]     m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_SIZE-1:0]     frames
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WIDTH = DATA_SIZE + 1;

  generate
    if (!is_pow2_min2(DEPTH)) begin : g_bad_depth
      $error("lc_stream_fifo: DEPTH must be a power of two and at least 2");
    end
    if (DATA_SIZE < 1) begin : g_bad_width
      $error("lc_stream_fifo: DATA_SIZE must be at least 1");
    end
  endgenerate

  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_nxt_s;
  logic [DATA_SIZE-1:0] frames_r;
  logic [WIDTH-1:0]     head_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;

  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign s_tready = !rst && !full_s;
  assign m_tvalid = !empty_s;
  assign push_s   = s_tvalid && s_tready;
  assign pop_s    = m_tvalid && m_tready;

  lc_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data ({s_tlast, s_tdata}),
    .rd_addr (rd_ptr_r),
    .rd_data (head_s)
  );

  assign m_tdata = head_s[DATA_SIZE-1:0];
  assign m_tlast = head_s[DATA_SIZE];
  assign count   = count_r;
  assign frames  = frames_r;

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and frame counter state; pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      frames_r <= {DATA_SIZE{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_nxt_s;
      if (pop_s && m_tlast) begin
        frames_r <= frames_r + DATA_SIZE'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_lc_stream_fifo.sv
// Directed scoreboard bench for lc_stream_fifo (DATA_SIZE=8, DEPTH=8).
module tb_lc_stream_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic [3:0]    count;
  logic [DW-1:0] frames;

  int          vecs = 0;
  int          miscompares = 0;
  bit          chk_en = 1'b0;
  logic [DW:0] exp_q[$];
  int          mcnt = 0;

  lc_stream_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .count(count), .frames(frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit ok = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = s_tready;
      step();
    end
    s_tvalid = 1'b0;
    if (!ok) begin
      vecs++;
      miscompares++;
      $display("FAIL send_timeout: beat %0h never accepted", d);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = (exp_q.size() == 0) && !m_tvalid;
    end
    if (!done) begin
      vecs++;
      miscompares++;
      $display("FAIL %s_drain_timeout: %0d beats still expected", name, exp_q.size());
    end
    chk({name, "_empty_count"}, 32'(count), 32'd0);
    chk({name, "_empty_valid"}, 32'(m_tvalid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("tready_during_rst", 32'(s_tready), 32'd0);
    step();
    rst = 1'b0;
  endtask

  // Occupancy model: checks handshake outputs and queues accepted beats as expected output.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit mready;
        bit mvalid;
        mready = !rst && (mcnt != DEPTH);
        mvalid = (mcnt != 0);
        chk("model_s_tready", 32'(s_tready), 32'(mready));
        chk("model_m_tvalid", 32'(m_tvalid), 32'(mvalid));
        chk("model_count", 32'(count), 32'(mcnt));
        if (count > 4'd8) begin
          miscompares++;
          $display("FAIL count_bound: got %0d, required at most 8", count);
        end
        if (rst) begin
          mcnt = 0;
          exp_q.delete();
        end else begin
          if (s_tvalid && mready) begin
            exp_q.push_back({s_tlast, s_tdata});
            mcnt++;
          end
          if (mvalid && m_tready) mcnt--;
        end
      end
    end
  end

  // Monitor: compares every beat the DUT hands over against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          vecs++;
          miscompares++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", {m_tlast, m_tdata});
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("out_beat", 32'({m_tlast, m_tdata}), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] stream_v [12] = '{8'd5, 8'd123, 8'd5, 8'd3, 8'd5, 8'd4,
                                     8'd2, 8'd1, 8'd0, 8'd26, 8'd255, 8'd255};
    int k;
    int cyc;
    bit acc;

    // Reset then idle.
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("tready_in_reset", 32'(s_tready), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_s_tready", 32'(s_tready), 32'd1);
      chk("idle_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_frames", 32'(frames), 32'd0);
    end
    step();

    // Fill then drain; the 0xAA beat offered while full must be refused.
    m_tready = 1'b0;
    for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0);
    @(negedge clk);
    chk("full_count", 32'(count), 32'd8);
    chk("full_s_tready", 32'(s_tready), 32'd0);
    step();
    s_tdata  = 8'hAA;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_hold_s_tready", 32'(s_tready), 32'd0);
      chk("full_hold_count", 32'(count), 32'd8);
      step();
    end
    s_tvalid = 1'b0;
    chk("full_head_data", 32'(m_tdata), 32'd1);
    m_tready = 1'b1;
    wait_drain("fill");
    chk("fill_frames", 32'(frames), 32'd0);

    // Twelve-beat frame streamed with the consumer always ready.
    for (int i = 0; i < 12; i++) send(stream_v[i], (i == 11));
    wait_drain("stream");
    chk("stream_frames", 32'(frames), 32'd1);

    // Push and pop together at count=1.
    m_tready = 1'b0;
    send(8'h11, 1'b0);
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_tdata = DW'($urandom);
      @(negedge clk);
      chk("simul_count", 32'(count), 32'd1);
      step();
    end
    s_tvalid = 1'b0;
    wait_drain("simul");
    chk("simul_frames", 32'(frames), 32'd1);

    // Random backpressure, 200 beats, tlast on every 7th.
    do_reset();
    k = 0;
    cyc = 0;
    while (k < 200 && cyc < 5000) begin
      s_tvalid = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      s_tdata  = DW'(k);
      s_tlast  = ((k % 7) == 6);
      @(negedge clk);
      acc = s_tvalid && s_tready;
      step();
      if (acc) k++;
      cyc++;
    end
    if (k < 200) begin
      vecs++;
      miscompares++;
      $display("FAIL random_timeout: got %0d beats, required 200", k);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    wait_drain("random");
    chk("random_frames", 32'(frames), 32'd28);

    // Reset mid-stream with beats buffered.
    do_reset();
    m_tready = 1'b1;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    wait_drain("pre_reset");
    chk("pre_reset_frames", 32'(frames), 32'd2);
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(DW'(8'h10 + i), 1'b0);
    @(negedge clk);
    chk("buffered_count", 32'(count), 32'd5);
    chk("buffered_frames", 32'(frames), 32'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_count", 32'(count), 32'd0);
    chk("post_reset_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("post_reset_frames", 32'(frames), 32'd0);
    step();
    send(8'h3C, 1'b0);
    chk("post_reset_head_valid", 32'(m_tvalid), 32'd1);
    chk("post_reset_head_data", 32'(m_tdata), 32'h3C);
    m_tready = 1'b1;
    wait_drain("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
